comm_arbiter: RTL and testbench

- Sequences and shares the CommMaster UART command link between two requesters, e.g. the control FSM and the debug/test interface.
- Grants one requester at a time (round-robin) and launches its 8-bit cmd / 16-bit data frame.
- Waits for frame-sent and then for the response byte, with a timeout.
- Returns the response or an error flag to the granted requester.

---
 rtl/comm_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_comm_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_arbiter.sv
// comm_arbiter: round-robin sharing of the CommMaster UART command link between two requesters.
// Optional resend-on-timeout is compiled in with the COMM_ARB_RETRY_EN macro.
module comm_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [7:0]  cmd0,
    input  logic [15:0] data0,
    output logic        done0,
    output logic [7:0]  resp0,
    output logic        err0,
    input  logic        req1,
    input  logic [7:0]  cmd1,
    input  logic [15:0] data1,
    output logic        done1,
    output logic [7:0]  resp1,
    output logic        err1,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        snd_cmd,
    input  logic        frm_snt,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        busy
);

    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    // Elaboration guard: timer needs at least two wait cycles, retry counter stays within a byte.
    if (TIMEOUT_CYCLES < 2 || MAX_RETRY > 255) begin : g_param_check
        $error("comm_arbiter: TIMEOUT_CYCLES must be >= 2 and MAX_RETRY <= 255");
    end

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SNT,
        WAIT_RESP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_gnt_q, last_gnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [7:0]  cmd_d;
    logic [15:0] data_d;
    logic        snd_cmd_d;
    logic        done0_d, done1_d;
    logic [7:0]  resp0_d, resp1_d;
    logic        err0_d, err1_d;
    logic        busy_d;

    logic        fin;
    logic        fin_err;
    logic        timed_out;

`ifdef COMM_ARB_RETRY_EN
    localparam int unsigned RTY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
    logic [RTY_W-1:0] retry_q, retry_d;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            timer_q    <= '0;
            cmd        <= '0;
            data       <= '0;
            snd_cmd    <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            resp0      <= '0;
            resp1      <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            busy       <= 1'b0;
`ifdef COMM_ARB_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            timer_q    <= timer_d;
            cmd        <= cmd_d;
            data       <= data_d;
            snd_cmd    <= snd_cmd_d;
            done0      <= done0_d;
            done1      <= done1_d;
            resp0      <= resp0_d;
            resp1      <= resp1_d;
            err0       <= err0_d;
            err1       <= err1_d;
            busy       <= busy_d;
`ifdef COMM_ARB_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        timer_d    = timer_q;
        cmd_d      = cmd;
        data_d     = data;
        snd_cmd_d  = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        resp0_d    = resp0;
        resp1_d    = resp1;
        err0_d     = err0;
        err1_d     = err1;
        busy_d     = 1'b0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        timed_out  = 1'b0;
`ifdef COMM_ARB_RETRY_EN
        retry_d    = retry_q;
`endif

        unique case (state_q)
            IDLE: begin
`ifdef COMM_ARB_RETRY_EN
                retry_d = '0;
`endif
                if (req0 || req1) begin
                    gnt_d   = (req0 && req1) ? ~last_gnt_q : req1;
                    cmd_d   = gnt_d ? cmd1 : cmd0;
                    data_d  = gnt_d ? data1 : data0;
                    state_d = SEND;
                end
            end
            SEND: begin
                timer_d = '0;
                state_d = WAIT_SNT;
            end
            WAIT_SNT, WAIT_RESP: begin
                timer_d = timer_q + TMR_W'(1);
                // A response in the last wait cycle still beats the timeout
                if (resp_rdy) begin
                    fin = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    timed_out = 1'b1;
                end else if (state_q == WAIT_SNT && frm_snt) begin
                    state_d = WAIT_RESP;
                end
            end
            DONE: begin
                last_gnt_d = gnt_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timed_out) begin
`ifdef COMM_ARB_RETRY_EN
            if (retry_q < RTY_MAX) begin
                retry_d = retry_q + RTY_W'(1);
                state_d = SEND;
            end else begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end
`else
            fin     = 1'b1;
            fin_err = 1'b1;
`endif
        end

        // Completion: response byte only overwritten on success
        if (fin) begin
            state_d = DONE;
            if (gnt_q) begin
                done1_d = 1'b1;
                err1_d  = fin_err;
                if (!fin_err) begin
                    resp1_d = resp;
                end
            end else begin
                done0_d = 1'b1;
                err0_d  = fin_err;
                if (!fin_err) begin
                    resp0_d = resp;
                end
            end
        end

        snd_cmd_d = (state_d == SEND);
        busy_d    = (state_d != IDLE);
    end

endmodule

// File: tb/tb_comm_arbiter.sv
// tb_comm_arbiter: directed vectors for comm_arbiter with a small CommMaster responder.
// Expected retry behaviour follows COMM_ARB_RETRY_EN when the bench is built with it.
module tb_comm_arbiter;

    localparam int TO        = 64;
    localparam int MAX_RETRY = 2;
`ifdef COMM_ARB_RETRY_EN
    localparam int ATTEMPTS = MAX_RETRY + 1;
`else
    localparam int ATTEMPTS = 1;
`endif
    localparam int TO_DONE = 1 + ATTEMPTS * (TO + 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [7:0]  cmd0, cmd1;
    logic [15:0] data0, data1;
    logic        done0, done1;
    logic [7:0]  resp0, resp1;
    logic        err0, err1;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        snd_cmd;
    logic        frm_snt;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        busy;
    logic [45:0] all_outs;

    int vectors     = 0;
    int miscompares = 0;

    assign all_outs = {busy, snd_cmd, done0, done1, err0, err1, cmd, data, resp0, resp1};

    always #5 clk = ~clk;

    comm_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .cmd0    (cmd0),
        .data0   (data0),
        .done0   (done0),
        .resp0   (resp0),
        .err0    (err0),
        .req1    (req1),
        .cmd1    (cmd1),
        .data1   (data1),
        .done1   (done1),
        .resp1   (resp1),
        .err1    (err1),
        .cmd     (cmd),
        .data    (data),
        .snd_cmd (snd_cmd),
        .frm_snt (frm_snt),
        .resp_rdy(resp_rdy),
        .resp    (resp),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CommMaster model: called in the grant cycle (cycle 0); returns in the done cycle.
    task automatic serve(input int snt_at, input int rdy_at, input logic [7:0] r,
                         input logic [7:0] ecmd, input logic [15:0] edata,
                         output int done_at, output int gnt, output int snd_cnt,
                         output int first_snd);
        done_at   = -1;
        gnt       = -1;
        snd_cnt   = 0;
        first_snd = -1;
        for (int c = 1; c <= 400; c++) begin
            tick();
            frm_snt  = 1'b0;
            resp_rdy = 1'b0;
            if (snd_cmd) begin
                snd_cnt++;
                if (first_snd < 0) first_snd = c;
                check("snd_frame", 64'({cmd, data}), 64'({ecmd, edata}));
            end
            if (done0 || done1) begin
                done_at = c;
                gnt     = done1 ? 1 : 0;
                break;
            end
            frm_snt  = (c == snt_at);
            resp_rdy = (c == rdy_at);
            if (c == rdy_at) resp = r;
        end
    endtask

    int done_at, gnt, snd_cnt, first_snd, exp_g;
    logic [7:0] exp_r;
    logic       done_seen;

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        cmd0 = '0; data0 = '0; cmd1 = '0; data1 = '0;
        frm_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
        tick();
        tick();
        check("reset_outs", 64'(all_outs), 64'(0));
        rst_n = 1'b1;

        // Stray CommMaster pulses in IDLE
        frm_snt = 1'b1; resp_rdy = 1'b1; resp = 8'hFF;
        tick();
        frm_snt = 1'b0; resp_rdy = 1'b0;
        tick();
        check("idle_ignore", 64'(all_outs), 64'(0));

        // Single transaction
        req0 = 1'b1; cmd0 = 8'hA5; data0 = 16'h1234;
        serve(10, 20, 8'hA5, 8'hA5, 16'h1234, done_at, gnt, snd_cnt, first_snd);
        req0 = 1'b0; cmd0 = 8'h00;
        check("single_first_snd", 64'(first_snd), 64'(1));
        check("single_snd_cnt", 64'(snd_cnt), 64'(1));
        check("single_done_at", 64'(done_at), 64'(21));
        check("single_done", 64'({done0, done1}), 64'(2'b10));
        check("single_resp_err", 64'({resp0, err0}), 64'({8'hA5, 1'b0}));
        tick();
        check("single_post", 64'({done0, done1, busy, cmd}), 64'({3'b000, 8'hA5}));

        // Response in the same cycle as frm_snt
        req0 = 1'b1; cmd0 = 8'h77; data0 = 16'hBEEF;
        serve(4, 4, 8'h3C, 8'h77, 16'hBEEF, done_at, gnt, snd_cnt, first_snd);
        req0 = 1'b0;
        check("same_cyc_done_at", 64'(done_at), 64'(5));
        check("same_cyc_result", 64'({done0, resp0, err0}), 64'({1'b1, 8'h3C, 1'b0}));
        tick();

        // Arbitration from reset: both requesting, 0 first then alternate
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0 = 1'b1; cmd0 = 8'h01; data0 = 16'h1001;
        req1 = 1'b1; cmd1 = 8'h02; data1 = 16'h2002;
        for (int k = 0; k < 4; k++) begin
            exp_g = k % 2;
            exp_r = (exp_g == 1) ? 8'h11 : 8'h22;
            serve(3, 6, exp_r, (exp_g == 1) ? 8'h02 : 8'h01,
                  (exp_g == 1) ? 16'h2002 : 16'h1001, done_at, gnt, snd_cnt, first_snd);
            check("arb_grant", 64'(gnt), 64'(exp_g));
            check("arb_done_at", 64'(done_at), 64'(7));
            if (exp_g == 1) begin
                check("arb_resp1", 64'({resp1, err1}), 64'({exp_r, 1'b0}));
                req1 = 1'b0;
            end else begin
                check("arb_resp0", 64'({resp0, err0}), 64'({exp_r, 1'b0}));
                req0 = 1'b0;
            end
            tick();
            if (exp_g == 1) req1 = 1'b1;
            else            req0 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check("arb_final_resps", 64'({resp0, resp1}), 64'({8'h22, 8'h11}));

        // Timeout: frame sent, no response
        req0 = 1'b1; cmd0 = 8'h5E; data0 = 16'h0F0F;
        serve(5, 0, 8'h99, 8'h5E, 16'h0F0F, done_at, gnt, snd_cnt, first_snd);
        req0 = 1'b0;
        check("to_done_at", 64'(done_at), 64'(TO_DONE));
        check("to_snd_cnt", 64'(snd_cnt), 64'(ATTEMPTS));
        check("to_result", 64'({done0, done1, err0, resp0}), 64'({3'b101, 8'h22}));
        tick();

        // Response in the timeout cycle wins
        req0 = 1'b1; cmd0 = 8'h6D; data0 = 16'h4321;
        serve(10, TO + 1, 8'h3C, 8'h6D, 16'h4321, done_at, gnt, snd_cnt, first_snd);
        req0 = 1'b0;
        check("to_edge_done_at", 64'(done_at), 64'(TO + 2));
        check("to_edge_result", 64'({done0, err0, resp0, snd_cnt[1:0]}),
              64'({2'b10, 8'h3C, 2'd1}));
        tick();

`ifdef COMM_ARB_RETRY_EN
        // Response only on the second attempt
        req0 = 1'b1; cmd0 = 8'h4B; data0 = 16'h5555;
        serve(0, TO + 6, 8'h44, 8'h4B, 16'h5555, done_at, gnt, snd_cnt, first_snd);
        req0 = 1'b0;
        check("retry2_snd_cnt", 64'(snd_cnt), 64'(2));
        check("retry2_result", 64'({done0, err0, resp0, 7'(done_at)}),
              64'({2'b10, 8'h44, 7'(TO + 7)}));
        tick();
`endif

        // Reset while in WAIT_RESP, then a late response
        req0 = 1'b1; cmd0 = 8'h33; data0 = 16'h3333;
        tick();
        tick();
        tick();
        frm_snt = 1'b1;
        tick();
        frm_snt = 1'b0;
        tick();
        rst_n = 1'b0; req0 = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_outs", 64'(all_outs), 64'(0));
        resp = 8'h77; resp_rdy = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            resp_rdy = 1'b0;
            done_seen = done_seen | done0 | done1;
        end
        check("midrst_no_done", 64'(done_seen), 64'(0));
        check("midrst_idle_outs", 64'(all_outs), 64'(0));

        req1 = 1'b1; cmd1 = 8'h5A; data1 = 16'hA55A;
        serve(2, 4, 8'h66, 8'h5A, 16'hA55A, done_at, gnt, snd_cnt, first_snd);
        req1 = 1'b0;
        check("post_rst_req1", 64'({gnt[1:0], done_at[7:0], resp1, err1}),
              64'({2'd1, 8'd5, 8'h66, 1'b0}));
        tick();

        req0 = 1'b1; cmd0 = 8'h01; data0 = 16'h1001;
        req1 = 1'b1; cmd1 = 8'h02; data1 = 16'h2002;
        serve(2, 3, 8'h12, 8'h01, 16'h1001, done_at, gnt, snd_cnt, first_snd);
        req0 = 1'b0; req1 = 1'b0;
        check("post_rst_tie", 64'({gnt[1:0], resp0}), 64'({2'd0, 8'h12}));
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
